// File: rtl/pixel_pkg.sv
// Shared pixel-level types and constants for the charge-summing sequencer.
package pixel_pkg;

    // Three neighbour summing discriminators, four pairwise winner votes.
    localparam int N_DISC_NB = 3;
    localparam int N_VOTE    = 4;

    // Event sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DEAD  = 2'd3
    } cs_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and sticky overflow flag.
module sat_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [CNT_W-1:0] count_d, count_q;
    logic             ovf_d, ovf_q;

    // Next count: clear wins over increment; at all-ones hold and flag overflow.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (&count_q) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/cs_event_sequencer.sv
// Per-pixel charge-summing event sequencer: trigger detect, arbitration
// window, single count per event, and dead time before re-arming.
module cs_event_sequencer
    import pixel_pkg::*;
#(
    parameter int WIN_LEN  = 4,
    parameter int DEAD_LEN = 8,
    parameter int CNT_W    = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 csm_en,
    input  logic                 shutter,
    input  logic                 clr_cnt,
    input  logic                 discLocal,
    input  logic [N_DISC_NB-1:0] discNeighbour,
    input  logic [N_VOTE-1:0]    winVote,
    output logic                 sync_enable,
    output logic                 winerAll,
    output logic                 hitPulse,
    output logic                 busy,
    output logic [CNT_W-1:0]     count,
    output logic                 ovf
);

    localparam logic [3:0] WIN_LOAD  = 4'(WIN_LEN - 1);
    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_LEN - 1);

    cs_state_t  state_d, state_q;
    logic [3:0] win_cnt_d, win_cnt_q;
    logic [7:0] dead_cnt_d, dead_cnt_q;
    logic       win_acc_d, win_acc_q;
    logic       disc_prev_q;

    logic       trigger;
    logic       win_acc_next;
    logic       hit;
    logic       cnt_inc;

    // Rising edge of the local discriminator, accepted only while armed and open.
    assign trigger      = discLocal & ~disc_prev_q & shutter & (state_q == ST_IDLE);
    // Accumulator including this cycle's votes; used for the final decision.
    assign win_acc_next = win_acc_q & (&winVote);
    // In summing mode the local node must win and all neighbours must coincide.
    assign hit          = csm_en ? (win_acc_next & discLocal & (&discNeighbour)) : 1'b1;

    // State register plus window/dead counters, accumulator and edge detector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            win_cnt_q   <= '0;
            dead_cnt_q  <= '0;
            win_acc_q   <= 1'b0;
            disc_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            dead_cnt_q  <= dead_cnt_d;
            win_acc_q   <= win_acc_d;
            disc_prev_q <= discLocal;
        end
    end

    // Next-state and counter updates; DEAD releases only once the
    // discriminator has dropped so a held input cannot retrigger.
    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        dead_cnt_d = dead_cnt_q;
        win_acc_d  = win_acc_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d   = ST_ARB;
                    win_cnt_d = WIN_LOAD;
                    win_acc_d = 1'b1;
                end
            end
            ST_ARB: begin
                win_acc_d = win_acc_next;
                if (win_cnt_q == 4'd0) begin
                    if (hit) begin
                        state_d = ST_COUNT;
                    end else begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = DEAD_LOAD;
                    end
                end else begin
                    win_cnt_d = win_cnt_q - 1'b1;
                end
            end
            ST_COUNT: begin
                state_d    = ST_DEAD;
                dead_cnt_d = DEAD_LOAD;
            end
            ST_DEAD: begin
                if (dead_cnt_q == 8'd0) begin
                    if (!discLocal) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    dead_cnt_d = dead_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        sync_enable = csm_en & (state_q == ST_ARB);
        winerAll    = win_acc_q & (state_q == ST_ARB);
        hitPulse    = (state_q == ST_COUNT);
        busy        = (state_q != ST_IDLE);
        cnt_inc     = (state_q == ST_COUNT);
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (cnt_inc),
        .count (count),
        .ovf   (ovf)
    );

endmodule
